mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 4:1 DATA_W-bit mux channel among four requesters (a,b,c,d).

---
 rtl/mux_arb_pkg.sv | 24 ++
 rtl/mux_rr_arbiter_rr_pick.sv | 18 +
 rtl/mux_rr_arbiter.sv | 109 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [1:0] A = 2'd0;
   localparam logic [1:0] B = 2'd1;
   localparam logic [1:0] C = 2'd2;
   localparam logic [1:0] D = 2'd3;

   // Requester index -> {s1,s2} mux select encoding.
   function automatic logic [1:0] sel_of(input logic [1:0] idx);
      logic [1:0] sel;
      unique case (idx)
         A:       sel = 2'b11;
         B:       sel = 2'b10;
         C:       sel = 2'b01;
         D:       sel = 2'b00;
         default: sel = 2'b00;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or above ptr, wrapping 3->0.
module rr_pick (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic       hit,
   output logic [1:0] idx
);

   // Walk from the farthest offset down so the nearest one to ptr wins.
   always_comb begin
      hit = |req;
      idx = ptr;
      for (int i = 3; i >= 0; i--) begin
         if (req[ptr + 2'(i)]) idx = ptr + 2'(i);
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning a 4:1 mux channel; define MUX_ARB_BURST_LIMIT_EN
// to force release after MAX_BURST transferred beats per grant.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DATA_W    = 4,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        req,
   input  logic [3:0]        last,
   input  logic [DATA_W-1:0] data_a,
   input  logic [DATA_W-1:0] data_b,
   input  logic [DATA_W-1:0] data_c,
   input  logic [DATA_W-1:0] data_d,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [3:0]        gnt,
   output logic              s1,
   output logic              s2
);

   state_t     state, state_nx;
   logic [1:0] owner, owner_nx, ptr, ptr_nx, pick, sel_nx;
   logic [3:0] gnt_nx;
   logic       hit, in_grant, xfer, burst_end, done;

   rr_pick u_pick (.req(req), .ptr(ptr), .hit(hit), .idx(pick));

   assign in_grant  = (state == GRANT);
   assign out_valid = in_grant & req[owner];
   assign out_last  = in_grant & last[owner];
   assign xfer      = out_valid & out_ready;
   // A dropped request releases the channel just like a completed packet.
   assign done      = in_grant & (~req[owner] | (xfer & last[owner]) | burst_end);

   always_comb begin
      out_data = data_a;
      unique case (owner)
         A: out_data = data_a;
         B: out_data = data_b;
         C: out_data = data_c;
         D: out_data = data_d;
         default: out_data = data_a;
      endcase
   end

`ifdef MUX_ARB_BURST_LIMIT_EN
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   logic [CNT_W-1:0] beats;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    beats <= '0;
      else if (!in_grant && hit)     beats <= '0;
      else if (xfer)                 beats <= beats + CNT_W'(1);
   end

   assign burst_end = xfer & (beats == CNT_W'(MAX_BURST - 1));
`else
   assign burst_end = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      owner_nx = owner;
      gnt_nx   = gnt;
      sel_nx   = {s1, s2};
      ptr_nx   = ptr;
      unique case (state)
         IDLE: begin
            gnt_nx = '0;
            if (hit) begin
               state_nx = GRANT;
               owner_nx = pick;
               gnt_nx   = 4'b0001 << pick;
               sel_nx   = sel_of(pick);
            end
         end
         GRANT: begin
            if (done) begin
               state_nx = IDLE;
               gnt_nx   = '0;
               ptr_nx   = owner + 2'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= '0;
         gnt      <= '0;
         {s1, s2} <= 2'b00;
         ptr      <= '0;
      end else begin
         state    <= state_nx;
         owner    <= owner_nx;
         gnt      <= gnt_nx;
         {s1, s2} <= sel_nx;
         ptr      <= ptr_nx;
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: vector table, directed corner sequences and a
// randomized run checked every cycle against a transaction-level model.
module tb_mux_rr_arbiter;

   localparam int DW = 4;
   localparam int MB = 4;
`ifdef MUX_ARB_BURST_LIMIT_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    req = '0, last = '0;
   logic          rdy = 1'b0;
   logic [DW-1:0] dat [4];
   logic          out_valid, out_last, s1, s2;
   logic [DW-1:0] out_data;
   logic [3:0]    gnt;

   int n_chk = 0, n_fail = 0;

   // Model: who owns the channel, rotation pointer, beats in this grant.
   bit m_busy, m_have;
   int m_owner, m_ptr, m_beats;

   typedef struct {
      logic [3:0] req, last;
      logic       rdy;
      logic [3:0] e_gnt;
      logic       e_valid;
      logic [1:0] e_sel;
   } vec_t;
   vec_t tbl [10];

   always #5 clk = ~clk;

   mux_rr_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last),
      .data_a(dat[0]), .data_b(dat[1]), .data_c(dat[2]), .data_d(dat[3]),
      .out_valid(out_valid), .out_ready(rdy), .out_data(out_data),
      .out_last(out_last), .gnt(gnt), .s1(s1), .s2(s2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_sel();
      if (!m_have) return 2'b00;
      return {m_owner < 2, (m_owner % 2) == 0};
   endfunction

   task automatic check_all();
      chk("gnt", gnt, m_busy ? 32'(1 << m_owner) : 32'd0);
      chk("s1s2", {s1, s2}, exp_sel());
      chk("out_valid", out_valid, m_busy && req[m_owner]);
      chk("out_last", out_last, m_busy && last[m_owner]);
      if (m_busy) chk("out_data", out_data, dat[m_owner]);
   endtask

   task automatic model_edge();
      if (!rst_n) return;
      if (!m_busy) begin
         if (req != 4'b0) begin
            for (int i = 0; i < 4; i++) begin
               int k = (m_ptr + i) % 4;
               if (req[k]) begin m_owner = k; break; end
            end
            m_busy = 1; m_have = 1; m_beats = 0;
         end
      end else begin
         bit take = req[m_owner] && rdy;
         if (!req[m_owner] || (take && last[m_owner]) ||
             (BURST && take && (m_beats + 1 == MB))) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % 4;
         end else if (take) m_beats++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic model_reset();
      m_busy = 0; m_have = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) dat[i] = DW'(i + 1);
      tbl[0] = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'b11};
      tbl[1] = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'b11};
      tbl[2] = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 2'b10};
      tbl[3] = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'b10};
      tbl[4] = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 2'b01};
      tbl[5] = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'b01};
      tbl[6] = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 2'b00};
      tbl[7] = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'b00};
      tbl[8] = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'b11};
      tbl[9] = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 2'b11};

      // Reset with a and c requesting; a first, then c after a releases.
      req = 4'b0101; last = 4'b0000; rdy = 1'b1;
      apply_reset();
      chk("reset_gnt", gnt, 4'b0000);
      chk("reset_valid", out_valid, 1'b0);
      step();
      chk("first_gnt_a", gnt, 4'b0001);
      chk("first_sel_a", {s1, s2}, 2'b11);
      last = 4'b0001;
      step();
      chk("a_released", gnt, 4'b0000);
      step();
      chk("next_is_c", gnt, 4'b0100);

      // Full contention, single-beat packets: strict rotation with a bubble.
      apply_reset();
      foreach (tbl[i]) begin
         req = tbl[i].req; last = tbl[i].last; rdy = tbl[i].rdy;
         step();
         chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].e_gnt);
         chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_valid);
         chk($sformatf("tbl%0d_sel", i), {s1, s2}, tbl[i].e_sel);
      end

      // b owns, downstream stalls: beat held stable, release on last.
      dat[1] = 4'hA;
      req = 4'b0010; last = 4'b0000; rdy = 1'b0;
      apply_reset();
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_valid", out_valid, 1'b1);
         chk("stall_data", out_data, 4'hA);
      end
      rdy = 1'b1; last = 4'b0010;
      step();
      chk("stall_release", gnt, 4'b0000);

      // c aborts mid-packet; d is next.
      req = 4'b1100; last = 4'b0000; rdy = 1'b1;
      apply_reset();
      step();
      chk("c_granted", gnt, 4'b0100);
      step();
      req = 4'b1000;
      step();
      chk("abort_idle", gnt, 4'b0000);
      step();
      chk("abort_next_d", gnt, 4'b1000);

      // Async reset mid-packet with d owning at beat 3.
      req = 4'b1000; last = 4'b0000; rdy = 1'b1;
      apply_reset();
      step(); step(); step();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_gnt", gnt, 4'b0000);
      chk("async_valid", out_valid, 1'b0);
      chk("async_sel", {s1, s2}, 2'b00);
      @(posedge clk); #1;
      rst_n = 1'b1;

`ifdef MUX_ARB_BURST_LIMIT_EN
      // Burst limit: a forced off after MB beats, b served, a resumes.
      req = 4'b0011; last = 4'b0000; rdy = 1'b1;
      apply_reset();
      step();
      chk("burst_a", gnt, 4'b0001);
      for (int i = 0; i < MB; i++) step();
      chk("burst_release", gnt, 4'b0000);
      last = 4'b0010;
      step();
      chk("burst_b", gnt, 4'b0010);
      step(); step();
      chk("burst_a_resume", gnt, 4'b0001);
`endif

      // Randomized traffic against the model.
      req = '0; last = '0; rdy = 1'b0;
      apply_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            last[i] = ($urandom_range(0, 3) == 0);
            dat[i]  = DW'($urandom);
         end
         rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 499) == 0) apply_reset();
         else step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
